// File: rtl/life_matrix_scan_if.sv
`default_nettype none
// ============================================================================
//  Module      : life_matrix_scan_if
//  Description : Generation input / LED-matrix output bundle for the scanner.
//  Revision    : 1.0  initial release
// ============================================================================
interface life_matrix_scan_if;
    logic [63:0] grid;
    logic        grid_valid;
    logic        en;
    logic [7:0]  row;
    logic [7:0]  col;
    logic        frame_done;
    logic        update_pend;

    modport master (
        output grid, grid_valid, en,
        input  row, col, frame_done, update_pend
    );

    modport slave (
        input  grid, grid_valid, en,
        output row, col, frame_done, update_pend
    );
endinterface
`default_nettype wire

// File: rtl/life_matrix_scan.sv
`default_nettype none
// ============================================================================
//  Module      : life_matrix_scan
//  Description : Row-scanned 8x8 LED driver with frame-boundary generation swap.
//  Revision    : 1.0  initial release
// ============================================================================
module life_matrix_scan #(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input wire                 clk,
    input wire                 reset,
    life_matrix_scan_if.slave  bus
);

    localparam int c_MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_DWELL_LAST = c_CNT_W'(DWELL_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_BLANK_LAST =
        c_CNT_W'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    // Every row slot begins here; with no blanking a row follows the previous one directly.
    localparam state_t c_ROW_ENTRY = (BLANK_CYCLES > 0) ? ST_BLANK : ST_DRIVE;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [2:0]           r_r;
    logic [2:0]           w_r_nxt;
    logic                 w_swap;

    logic [63:0]          r_pending;
    logic [63:0]          r_shadow;
    logic                 r_update_pend;

    logic [7:0]           r_row;
    logic [7:0]           r_col;
    logic                 r_frame_done;
    logic [7:0]           w_row_nxt;
    logic [7:0]           w_col_nxt;
    logic                 w_frame_done_nxt;

    logic [7:0]           w_rows [8];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rows
            assign w_rows[gi] = r_shadow[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_r     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_r     <= w_r_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt + 1'b1;
        w_r_nxt          = r_r;
        w_swap           = 1'b0;
        w_row_nxt        = 8'h00;
        w_col_nxt        = 8'h00;
        w_frame_done_nxt = 1'b0;

        if (!bus.en) begin
            // Disable abandons the frame immediately; outputs go dark next cycle.
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_r_nxt     = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_swap      = 1'b1;
                    w_r_nxt     = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_ROW_ENTRY;
                end
                ST_BLANK: begin
                    if (r_cnt == c_BLANK_LAST) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    w_row_nxt = 8'b1 << r_r;
                    w_col_nxt = w_rows[r_r];
                    if (r_cnt == c_DWELL_LAST) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = c_ROW_ENTRY;
                        if (r_r == 3'd7) begin
                            w_frame_done_nxt = 1'b1;
                            w_swap           = 1'b1;
                            w_r_nxt          = '0;
                        end else begin
                            w_r_nxt = r_r + 3'd1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_r_nxt     = '0;
                end
            endcase
        end
    end

    // A generation arriving on the swap cycle itself goes straight to the display.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending     <= '0;
            r_shadow      <= '0;
            r_update_pend <= 1'b0;
        end else begin
            if (bus.grid_valid) begin
                r_pending <= bus.grid;
            end
            if (w_swap && (r_update_pend || bus.grid_valid)) begin
                r_shadow <= bus.grid_valid ? bus.grid : r_pending;
            end
            if (w_swap) begin
                r_update_pend <= 1'b0;
            end else if (bus.grid_valid) begin
                r_update_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_row        <= 8'h00;
            r_col        <= 8'h00;
            r_frame_done <= 1'b0;
        end else begin
            r_row        <= w_row_nxt;
            r_col        <= w_col_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    assign bus.row         = r_row;
    assign bus.col         = r_col;
    assign bus.frame_done  = r_frame_done;
    assign bus.update_pend = r_update_pend;

endmodule
`default_nettype wire

// File: tb/tb_life_matrix_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_life_matrix_scan
//  Description : Self-checking bench: two scanner configurations vs. a phase model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_life_matrix_scan;

    localparam int c_DW_A = 4;
    localparam int c_BL_A = 1;
    localparam int c_DW_B = 1;
    localparam int c_BL_B = 0;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] grid;
    logic        grid_valid;
    logic        en;

    life_matrix_scan_if bus_a ();
    life_matrix_scan_if bus_b ();

    assign bus_a.grid       = grid;
    assign bus_a.grid_valid = grid_valid;
    assign bus_a.en         = en;
    assign bus_b.grid       = grid;
    assign bus_b.grid_valid = grid_valid;
    assign bus_b.en         = en;

    life_matrix_scan #(.DWELL_CYCLES(c_DW_A), .BLANK_CYCLES(c_BL_A)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    life_matrix_scan #(.DWELL_CYCLES(c_DW_B), .BLANK_CYCLES(c_BL_B)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    // Scan position is a single phase index into the frame: slot = p/(dwell+blank).
    typedef struct {
        bit          active;
        int          p;
        logic [63:0] shadow;
        logic [63:0] pending;
        bit          upd;
    } model_t;

    model_t ma, mb;
    int     checks = 0;
    int     errors = 0;
    int     cyc    = 0;
    bit     diag_mode = 1'b0;
    int     last_fd_a = -1;
    int     last_fd_b = -1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_step(input model_t mi, input int dw, input int bl,
                              output model_t mo, output logic [7:0] erow,
                              output logic [7:0] ecol, output logic efd);
        int          per;
        int          slot;
        int          off;
        bit          swap;
        logic [63:0] sh;
        per  = 8 * (dw + bl);
        mo   = mi;
        erow = 8'h00;
        ecol = 8'h00;
        efd  = 1'b0;
        if (reset) begin
            mo.active  = 1'b0;
            mo.p       = 0;
            mo.shadow  = '0;
            mo.pending = '0;
            mo.upd     = 1'b0;
            return;
        end
        if (mi.active && en) begin
            slot = mi.p / (dw + bl);
            off  = mi.p % (dw + bl);
            sh   = mi.shadow;
            if (off >= bl) begin
                erow = 8'(1 << slot);
                ecol = sh[8*slot +: 8];
                efd  = (mi.p == per - 1);
            end
        end
        swap = en && (!mi.active || mi.p == per - 1);
        if (grid_valid) begin
            mo.pending = grid;
            mo.upd     = 1'b1;
        end
        if (swap) begin
            if (mi.upd || grid_valid) mo.shadow = grid_valid ? grid : mi.pending;
            mo.upd = 1'b0;
        end
        if (!en) begin
            mo.active = 1'b0;
            mo.p      = 0;
        end else if (!mi.active) begin
            mo.active = 1'b1;
            mo.p      = 0;
        end else begin
            mo.p = (mi.p + 1) % per;
        end
    endtask

    task automatic tick();
        logic [7:0] era, eca, erb, ecb;
        logic       efa, efb;
        bit         quiet;
        @(posedge clk);
        quiet = reset || !en;
        model_step(ma, c_DW_A, c_BL_A, ma, era, eca, efa);
        model_step(mb, c_DW_B, c_BL_B, mb, erb, ecb, efb);
        #1;
        cyc++;
        check("a_row", bus_a.row, era);
        check("a_col", bus_a.col, eca);
        check("a_frame_done", bus_a.frame_done, efa);
        check("a_update_pend", bus_a.update_pend, ma.upd);
        check("b_row", bus_b.row, erb);
        check("b_col", bus_b.col, ecb);
        check("b_frame_done", bus_b.frame_done, efb);
        check("b_update_pend", bus_b.update_pend, mb.upd);
        check("a_onehot", ($countones(bus_a.row) <= 1), 1);
        check("a_col_dark", (bus_a.row == 8'h00 && bus_a.col != 8'h00), 0);
        if (diag_mode && bus_a.row != 8'h00) check("a_diag", bus_a.col, bus_a.row);
        if (quiet) begin
            last_fd_a = -1;
            last_fd_b = -1;
        end else begin
            if (bus_a.frame_done) begin
                if (last_fd_a >= 0) check("a_fd_period", cyc - last_fd_a, 40);
                last_fd_a = cyc;
            end
            if (bus_b.frame_done) begin
                if (last_fd_b >= 0) check("b_fd_period", cyc - last_fd_b, 8);
                last_fd_b = cyc;
            end
        end
    endtask

    task automatic wait_row_a(input logic [7:0] target, input string tag);
        int n = 0;
        while (bus_a.row !== target && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, (bus_a.row === target), 1);
    endtask

    task automatic wait_fd_a(input string tag);
        int n = 0;
        while (bus_a.frame_done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, bus_a.frame_done, 1);
    endtask

    initial begin
        logic [63:0] ga, gb, gc;
        int          n;
        reset = 1'b1; en = 1'b0; grid_valid = 1'b0; grid = '0;
        ma = '{1'b0, 0, '0, '0, 1'b0};
        mb = '{1'b0, 0, '0, '0, 1'b0};
        tick(); tick();
        check("reset_row", bus_a.row, 8'h00);
        check("reset_pend", bus_a.update_pend, 0);

        // Diagonal pattern: each row lights only its own column.
        reset = 1'b0; en = 1'b1; grid_valid = 1'b1; grid = 64'h8040201008040201;
        tick();
        grid_valid = 1'b0;
        diag_mode = 1'b1;
        repeat (85) tick();
        diag_mode = 1'b0;

        // Full-on generation arriving mid-frame waits for the boundary.
        wait_row_a(8'h08, "t2_row3");
        grid = '1; grid_valid = 1'b1;
        tick();
        grid_valid = 1'b0;
        check("t2_pend_set", bus_a.update_pend, 1);
        wait_fd_a("t2_fd");
        wait_row_a(8'h01, "t2_row0");
        check("t2_col_ff", bus_a.col, 8'hFF);
        check("t2_pend_clr", bus_a.update_pend, 0);

        // Two captures in one frame: only the later one is shown.
        wait_row_a(8'h02, "t3_row1");
        ga = {$urandom, $urandom}; gb = {$urandom, $urandom};
        grid = ga; grid_valid = 1'b1; tick(); grid_valid = 1'b0;
        repeat (3) tick();
        grid = gb; grid_valid = 1'b1; tick(); grid_valid = 1'b0;
        wait_fd_a("t3_fd");
        wait_row_a(8'h01, "t3_row0");
        check("t3_col_b", bus_a.col, gb[7:0]);

        // Capture in the very last drive cycle of row 7 bypasses pending.
        n = 0;
        while (!(ma.active && ma.p == 8 * (c_DW_A + c_BL_A) - 1) && n < 100) begin
            tick();
            n++;
        end
        check("t4_sync_timeout", (ma.active && ma.p == 39), 1);
        gc = {$urandom, $urandom};
        grid = gc; grid_valid = 1'b1; tick(); grid_valid = 1'b0;
        wait_row_a(8'h01, "t4_row0");
        check("t4_col_c", bus_a.col, gc[7:0]);

        // Disable during row 5, then restart.
        wait_row_a(8'h20, "t5_row5");
        en = 1'b0;
        tick();
        check("t5_row_off", bus_a.row, 8'h00);
        check("t5_col_off", bus_a.col, 8'h00);
        check("t5_no_fd", bus_a.frame_done, 0);
        repeat (10) tick();
        en = 1'b1;
        n = 0;
        while (bus_a.row == 8'h00 && n < 20) begin
            tick();
            n++;
        end
        check("t5_restart_row0", bus_a.row, 8'h01);

        // Reset in the middle of a scan.
        repeat (13) tick();
        reset = 1'b1;
        tick();
        check("t6_b_row_rst", bus_b.row, 8'h00);
        check("t6_b_col_rst", bus_b.col, 8'h00);
        reset = 1'b0;

        // Randomized traffic: captures, enable drops and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            grid       = {$urandom, $urandom};
            grid_valid = ($urandom_range(0, 7) == 0);
            en         = ($urandom_range(0, 63) != 0);
            reset      = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
